apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
APB requester that drives the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus toward our APB slaves and collects PREADY/PRDATA/PSLVERR. A local single-command valid/ready interface feeds it, and each completed transfer is returned as a one-cycle response pulse. A wait-state watchdog aborts transfers whose slave never asserts PREADY. It sits between the system-side register bus and the peripheral APB segment.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr_i and PADDR_o
DATA_WIDTH, 8, width of write data, read data and response data
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with PREADY_i low before abort; 0 disables the watchdog

Ports:
PCLK  input  1  clock, all logic on rising edge
PPRESETn  input  1  reset, synchronous, active-low
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  command accepted when high together with cmd_valid_i at the clock edge
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_WIDTH  target address
cmd_wdata_i  input  DATA_WIDTH  write data
rsp_valid_o  output  1  one-cycle pulse when a transfer completes
rsp_rdata_o  output  DATA_WIDTH  read data (0 for writes and for timeouts)
rsp_err_o  output  1  slave error or timeout
rsp_timeout_o  output  1  transfer aborted by the watchdog
PSEL_o  output  1  APB select
PENABLE_o  output  1  APB enable
PWRITE_o  output  1  APB direction
PADDR_o  output  ADDR_WIDTH  APB address
PWDATA_o  output  DATA_WIDTH  APB write data
PREADY_i  input  1  slave ready
PRDATA_i  input  DATA_WIDTH  slave read data
PSLVERR_i  input  1  slave error

Behaviour:
- Reset: PPRESETn is synchronous and active-low, sampled on the PCLK rising edge. At that edge the state becomes IDLE and all registered outputs clear: PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, rsp_* all 0, wait counter 0. cmd_ready_o is decoded from state, so it is 1 after the reset edge.
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready_o = 1. If cmd_valid_i is high at the edge, register write/addr/wdata onto PWRITE_o/PADDR_o/PWDATA_o and go to SETUP. Otherwise stay in IDLE with PSEL_o = 0.
- SETUP: exactly one cycle. PSEL_o = 1, PENABLE_o = 0, cmd_ready_o = 0. Always goes to ACCESS.
- ACCESS: PSEL_o = 1, PENABLE_o = 1. PADDR_o, PWRITE_o and PWDATA_o are held stable from SETUP through the end of ACCESS.
- Completion: if PREADY_i = 1 at an ACCESS edge, go to IDLE. On that same edge, register rsp_valid_o = 1, rsp_err_o = PSLVERR_i, and rsp_rdata_o = PRDATA_i for reads (0 for writes). PSEL_o and PENABLE_o drop to 0.
- rsp_valid_o is high for exactly one cycle. rsp_rdata_o, rsp_err_o and rsp_timeout_o hold their values until the next response.
- PSLVERR_i and PRDATA_i are ignored except on the completing ACCESS edge.
- Wait counter: counts ACCESS cycles with PREADY_i = 0 and is cleared on entry to ACCESS. When TIMEOUT_CYCLES > 0 and the count reaches TIMEOUT_CYCLES with PREADY_i still 0, abort: go to IDLE, rsp_valid_o = 1, rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0. If PREADY_i = 1 on that same edge, normal completion wins.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- Latency: command accept edge to rsp_valid_o = 2 + N cycles, where N is the number of wait states. Minimum transfer period is 3 cycles.
- A new command can be accepted in the same cycle that rsp_valid_o is high, because the state is IDLE then. There is no pipelining beyond that.
- Reset mid-transfer (SETUP or ACCESS): PSEL_o and PENABLE_o drop at the reset edge. No response is emitted and the command is lost.
- cmd_* inputs are don't-care outside IDLE.

Decomposition:
- Package apb_pkg: enum apb_master_state_t {IDLE, SETUP, ACCESS} as logic [1:0], plus a shared default-width localparam for the APB segment.
- Sub-module apb_wait_timer, parameterised by TIMEOUT_CYCLES, with inputs clear and count-enable and output expired. It is instantiated once.
- All remaining logic is in apb_master.

Test Plan:
- Write, zero wait: cmd write addr 0x3 data 0xA5; slave PREADY = 1 immediately -> SETUP 1 cycle, ACCESS 1 cycle, PADDR = 0x3, PWDATA = 0xA5 stable; rsp_valid_o one pulse 2 cycles after accept, rsp_err_o = 0, rsp_rdata_o = 0.
- Read, 2 wait states: cmd read addr 0x7; PREADY_i low 2 cycles then high with PRDATA = 0x5C -> rsp_valid_o 4 cycles after accept, rsp_rdata_o = 0x5C, PENABLE_o high 3 cycles.
- Slave error: read addr 0x20, slave returns PREADY = 1 and PSLVERR = 1 -> rsp_err_o = 1, rsp_timeout_o = 0.
- Timeout, TIMEOUT_CYCLES = 4, PREADY_i held low -> abort after 4 ACCESS cycles: PSEL_o = 0, rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0. Repeat with PREADY_i rising on the 4th cycle -> normal completion.
- Back-to-back: cmd_valid_i held high with 3 commands, zero-wait slave -> accepts every 3 cycles, 3 rsp pulses in order, second accept coincides with the first rsp pulse.
- Reset in ACCESS: assert PPRESETn low during a wait state -> next edge PSEL_o = PENABLE_o = 0, no rsp_valid_o, cmd_ready_o = 1 after reset.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and default widths for the APB requester
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_master_state_t;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait-state counter with abort flag
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the waiting cycle that would bring the count up to the limit.
  assign expired_o = (TIMEOUT_CYCLES > 0) && count_en_i && (count_q == LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester with single-command front end and wait-state watchdog
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PPRESETn,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  PSEL_o,
  output logic                  PENABLE_o,
  output logic                  PWRITE_o,
  output logic [ADDR_WIDTH-1:0] PADDR_o,
  output logic [DATA_WIDTH-1:0] PWDATA_o,
  input  logic                  PREADY_i,
  input  logic [DATA_WIDTH-1:0] PRDATA_i,
  input  logic                  PSLVERR_i
);

  apb_master_state_t state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst_n     (PPRESETn),
    .clear_i   (state_q == SETUP),
    .count_en_i((state_q == ACCESS) && !PREADY_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write_i;
          paddr_d   = cmd_addr_i;
          pwdata_d  = cmd_wdata_i;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A ready slave wins over a watchdog expiry on the same edge.
        if (PREADY_i) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR_i;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA_i;
        end else if (expired) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PPRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign PSEL_o        = psel_q;
  assign PENABLE_o     = penable_q;
  assign PWRITE_o      = pwrite_q;
  assign PADDR_o       = paddr_q;
  assign PWDATA_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with a scripted APB slave
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int T  = 4;

  logic          PCLK = 1'b0;
  logic          PPRESETn;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic          PSEL_o;
  logic          PENABLE_o;
  logic          PWRITE_o;
  logic [AW-1:0] PADDR_o;
  logic [DW-1:0] PWDATA_o;
  logic          PREADY_i;
  logic [DW-1:0] PRDATA_i;
  logic          PSLVERR_i;

  int            sl_waits = 0;
  logic [DW-1:0] sl_rdata = '0;
  logic          sl_err   = 1'b0;
  logic          sl_echo  = 1'b0;
  int            acc_cnt  = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK         (PCLK),
    .PPRESETn     (PPRESETn),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .PSEL_o       (PSEL_o),
    .PENABLE_o    (PENABLE_o),
    .PWRITE_o     (PWRITE_o),
    .PADDR_o      (PADDR_o),
    .PWDATA_o     (PWDATA_o),
    .PREADY_i     (PREADY_i),
    .PRDATA_i     (PRDATA_i),
    .PSLVERR_i    (PSLVERR_i)
  );

  // Slave: stalls sl_waits ACCESS cycles, then completes; error/data are noisy while stalling.
  always @(posedge PCLK) begin
    if (PSEL_o && PENABLE_o && !PREADY_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign PREADY_i  = PSEL_o && PENABLE_o && (acc_cnt >= sl_waits);
  assign PSLVERR_i = PREADY_i ? sl_err : 1'b1;
  assign PRDATA_i  = PREADY_i ? (sl_echo ? (PADDR_o[7:0] ^ 8'h3C) : sl_rdata) : ~sl_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer from an idle negedge; expectations come from the transfer rules directly.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd, input logic er);
    logic          to;
    logic [DW-1:0] erd;
    logic          eerr;
    int            lat;
    int            pen;
    to   = (T > 0) && (waits >= T);
    erd  = (to || wr) ? '0 : rd;
    eerr = to ? 1'b1 : er;
    sl_waits = waits; sl_rdata = rd; sl_err = er; sl_echo = 1'b0;
    cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd; cmd_valid_i = 1'b1;
    check("ready_idle", cmd_ready_o, 1);
    @(negedge PCLK);
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = DW'($urandom); cmd_write_i = ~wr;
    check("setup_penable", PENABLE_o, 0);
    check("setup_ready", cmd_ready_o, 0);
    lat = 0; pen = 0;
    while (!rsp_valid_o && lat < 40) begin
      check("psel", PSEL_o, 1);
      check("paddr", PADDR_o, addr);
      check("pwdata", PWDATA_o, wd);
      check("pwrite", PWRITE_o, wr);
      if (PENABLE_o) pen++;
      @(negedge PCLK);
      lat++;
    end
    check("latency", lat, to ? T + 1 : 2 + waits);
    check("penable_cycles", pen, to ? T : waits + 1);
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_err", rsp_err_o, eerr);
    check("rsp_timeout", rsp_timeout_o, to);
    check("rsp_rdata", rsp_rdata_o, erd);
    check("end_psel", PSEL_o, 0);
    check("end_penable", PENABLE_o, 0);
    check("end_ready", cmd_ready_o, 1);
    @(negedge PCLK);
    check("rsp_pulse", rsp_valid_o, 0);
    check("hold_rdata", rsp_rdata_o, erd);
    check("hold_err", rsp_err_o, eerr);
    check("hold_timeout", rsp_timeout_o, to);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [AW-1:0] b_addr [3];
    int            acc_c[$];
    int            rsp_c[$];
    logic [DW-1:0] exp_q[$];
    int            idx;

    PPRESETn = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0;
    repeat (2) @(negedge PCLK);
    check("rst_psel", PSEL_o, 0);
    check("rst_penable", PENABLE_o, 0);
    check("rst_pwrite", PWRITE_o, 0);
    check("rst_paddr", PADDR_o, 0);
    check("rst_pwdata", PWDATA_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_timeout", rsp_timeout_o, 0);
    check("rst_ready", cmd_ready_o, 1);
    PPRESETn = 1'b1;
    @(negedge PCLK);

    xfer(1'b1, 32'h3, 8'hA5, 0, 8'h11, 1'b0);
    xfer(1'b0, 32'h7, 8'h00, 2, 8'h5C, 1'b0);
    xfer(1'b0, 32'h20, 8'h00, 0, 8'h77, 1'b1);
    xfer(1'b0, 32'h44, 8'h00, 50, 8'h99, 1'b0);
    xfer(1'b0, 32'h45, 8'h00, T - 1, 8'hC3, 1'b0);
    xfer(1'b1, 32'h46, 8'h3E, 50, 8'h00, 1'b0);

    for (int i = 0; i < 14; i++) begin
      xfer(1'($urandom), $urandom, DW'($urandom), $urandom_range(0, T + 2),
           DW'($urandom), 1'($urandom));
    end

    // Back-to-back reads with a zero-wait slave echoing a function of PADDR.
    sl_waits = 0; sl_echo = 1'b1; sl_err = 1'b0;
    for (int k = 0; k < 3; k++) b_addr[k] = $urandom;
    idx = 0;
    cmd_write_i = 1'b0; cmd_addr_i = b_addr[0]; cmd_valid_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (rsp_valid_o) begin
        rsp_c.push_back(c);
        if (exp_q.size() > 0) check("b2b_rdata", rsp_rdata_o, exp_q.pop_front());
      end
      if (cmd_valid_i && cmd_ready_o) begin
        acc_c.push_back(c);
        exp_q.push_back(b_addr[idx][7:0] ^ 8'h3C);
        idx++;
      end
      @(negedge PCLK);
      if (idx < 3) cmd_addr_i = b_addr[idx];
      else cmd_valid_i = 1'b0;
    end
    check("b2b_accepts", acc_c.size(), 3);
    check("b2b_rsps", rsp_c.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0 && k < acc_c.size()) check("b2b_accept_gap", acc_c[k] - acc_c[k-1], 3);
      if (k < acc_c.size() && k < rsp_c.size()) check("b2b_rsp_time", rsp_c[k], acc_c[k] + 3);
    end
    sl_echo = 1'b0;

    // Reset while the slave is stalling in ACCESS.
    sl_waits = 100;
    cmd_write_i = 1'b0; cmd_addr_i = 32'h1234; cmd_valid_i = 1'b1;
    @(negedge PCLK);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge PCLK);
    check("mid_psel", PSEL_o, 1);
    check("mid_penable", PENABLE_o, 1);
    PPRESETn = 1'b0;
    @(negedge PCLK);
    check("rstmid_psel", PSEL_o, 0);
    check("rstmid_penable", PENABLE_o, 0);
    check("rstmid_rsp_valid", rsp_valid_o, 0);
    check("rstmid_ready", cmd_ready_o, 1);
    PPRESETn = 1'b1;
    sl_waits = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      check("rstmid_no_rsp", rsp_valid_o, 0);
      check("rstmid_idle_psel", PSEL_o, 0);
    end
    xfer(1'b0, 32'h55, 8'h00, 1, 8'h6B, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
